// File: rtl/telemetry_check_multi.sv
// telemetry_check_multi: per-stream counter-pattern checker with lock/LED FSMs and muxed stats
// Optional TELEMETRY_CHECK_SATURATE_EN: 32-bit stats saturate instead of wrapping
module telemetry_check_multi #(
  parameter int          G_NUM_STREAMS = 4,
  parameter logic [3:0]  G_STREAM_BASE = 4'hD,
  parameter int          G_CNT_WIDTH   = 10,
  parameter int          G_GAP_MAX     = 8,
  parameter logic [19:0] g_match_cnt   = 20'h4ffff,
  parameter logic [15:0] g_timeout_cnt = 16'hffff
) (
  input  logic                     clk_256M,
  input  logic                     reset_n,
  input  logic [87:0]              packet_data,
  input  logic                     packet_valid,
  input  logic                     reset_counters,
  input  logic [3:0]               stat_sel,
  output logic [31:0]              total_packets,
  output logic [31:0]              foreign_packets,
  output logic [31:0]              sel_packets,
  output logic [31:0]              sel_mismatch,
  output logic [31:0]              sel_dropped,
  output logic [G_NUM_STREAMS-1:0] okay_led,
  output logic [G_NUM_STREAMS-1:0] link_count_okay
);
  localparam int N = G_NUM_STREAMS;
  localparam int W = G_CNT_WIDTH;
  typedef enum logic [1:0] {DOWN, ACQ, UP} state_t;
  state_t       st [N];
  state_t       st_nx [N];
  logic [19:0]  mcnt [N];
  logic [19:0]  mcnt_nx [N];
  logic [15:0]  tmr [N];
  logic [W-1:0] exp_cnt [N];
  logic [W-1:0] d [N];
  logic [31:0]  pkts [N];
  logic [31:0]  mism [N];
  logic [31:0]  drop [N];
  logic [N-1:0] sync, hit, match, gap, err;
  logic [31:0]  sel_p_nx, sel_m_nx, sel_d_nx;
  logic [W-1:0] rx;
  logic [4:0]   idx;
  logic         in_range, take, unused;
  function automatic logic [31:0] add(input logic [31:0] a, input logic [31:0] b);
`ifdef TELEMETRY_CHECK_SATURATE_EN
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
`else
    return a + b;
`endif
  endfunction
  assign rx       = packet_data[W-1:0];
  // ids below the base wrap to >= 16 here, so one compare covers both bounds
  assign idx      = {1'b0, packet_data[83:80]} - {1'b0, G_STREAM_BASE};
  assign in_range = idx < 5'(N);
  assign take     = packet_valid && !reset_counters;
  assign unused   = ^{packet_data[87:84], packet_data[79:W]};
  always_comb begin
    sel_p_nx = '0;
    sel_m_nx = '0;
    sel_d_nx = '0;
    for (int i = 0; i < N; i++) begin
      hit[i]     = take && in_range && idx == 5'(i);
      d[i]       = rx - exp_cnt[i];
      match[i]   = hit[i] && sync[i] && d[i] == '0;
      gap[i]     = hit[i] && sync[i] && d[i] != '0 && 32'(d[i]) <= 32'(G_GAP_MAX);
      err[i]     = hit[i] && sync[i] && !match[i] && !gap[i];
      st_nx[i]   = st[i];
      mcnt_nx[i] = mcnt[i];
      if (gap[i] || err[i] || (!hit[i] && tmr[i] == g_timeout_cnt)) begin
        st_nx[i]   = DOWN;
        mcnt_nx[i] = '0;
      end else if (match[i]) begin
        st_nx[i]   = st[i] == DOWN ? ACQ : (st[i] == ACQ && mcnt[i] >= g_match_cnt) ? UP : st[i];
        mcnt_nx[i] = st[i] == DOWN ? 20'd1 : st[i] == ACQ ? mcnt[i] + 20'd1 : mcnt[i];
      end
      okay_led[i]        = st[i] == UP;
      link_count_okay[i] = st[i] != DOWN;
      if (stat_sel == 4'(i)) begin
        sel_p_nx = pkts[i];
        sel_m_nx = mism[i];
        sel_d_nx = drop[i];
      end
    end
  end
  always_ff @(posedge clk_256M) begin
    if (!reset_n) begin
      total_packets   <= '0;
      foreign_packets <= '0;
      sel_packets     <= '0;
      sel_mismatch    <= '0;
      sel_dropped     <= '0;
      sync            <= '0;
      for (int i = 0; i < N; i++) begin
        st[i]      <= DOWN;
        mcnt[i]    <= '0;
        tmr[i]     <= '0;
        exp_cnt[i] <= '0;
        pkts[i]    <= '0;
        mism[i]    <= '0;
        drop[i]    <= '0;
      end
    end else begin
      total_packets   <= reset_counters ? '0 : packet_valid ? add(total_packets, 32'd1) : total_packets;
      foreign_packets <= reset_counters ? '0 : (packet_valid && !in_range) ? add(foreign_packets, 32'd1) : foreign_packets;
      sel_packets     <= sel_p_nx;
      sel_mismatch    <= sel_m_nx;
      sel_dropped     <= sel_d_nx;
      for (int i = 0; i < N; i++) begin
        st[i]   <= st_nx[i];
        mcnt[i] <= mcnt_nx[i];
        tmr[i]  <= hit[i] ? '0 : tmr[i] == g_timeout_cnt ? tmr[i] : tmr[i] + 16'd1;
        if (reset_counters) begin
          pkts[i] <= '0;
          mism[i] <= '0;
          drop[i] <= '0;
          sync[i] <= 1'b0;
        end else if (hit[i]) begin
          pkts[i]    <= add(pkts[i], 32'd1);
          mism[i]    <= (gap[i] || err[i]) ? add(mism[i], 32'd1) : mism[i];
          drop[i]    <= gap[i] ? add(drop[i], 32'(d[i])) : drop[i];
          sync[i]    <= 1'b1;
          exp_cnt[i] <= rx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_telemetry_check_multi.sv
// tb_telemetry_check_multi: scoreboard bench for telemetry_check_multi (N=4, W=10, base D)
module tb_telemetry_check_multi;
  localparam int N   = 4;
  localparam int TMO = 2000;
  logic          clk_256M = 1'b0;
  logic          reset_n, packet_valid, reset_counters;
  logic [87:0]   packet_data;
  logic [3:0]    stat_sel;
  logic [31:0]   total_packets, foreign_packets, sel_packets, sel_mismatch, sel_dropped;
  logic [N-1:0]  okay_led, link_count_okay;
  int            n_chk = 0, n_fail = 0;
  logic [7:0]    sb [$];
  logic          m_sync [N];
  logic [9:0]    m_exp [N];
  int unsigned   m_pk [N], m_mm [N], m_dr [N];
  int            m_st [N], m_mc [N];
  int unsigned   m_tot, m_for;
  always #2 clk_256M = ~clk_256M;
  telemetry_check_multi #(
    .G_NUM_STREAMS(N), .G_STREAM_BASE(4'hD), .G_CNT_WIDTH(10), .G_GAP_MAX(8),
    .g_match_cnt(20'd16), .g_timeout_cnt(16'(TMO))
  ) dut (
    .clk_256M(clk_256M), .reset_n(reset_n), .packet_data(packet_data),
    .packet_valid(packet_valid), .reset_counters(reset_counters), .stat_sel(stat_sel),
    .total_packets(total_packets), .foreign_packets(foreign_packets),
    .sel_packets(sel_packets), .sel_mismatch(sel_mismatch), .sel_dropped(sel_dropped),
    .okay_led(okay_led), .link_count_okay(link_count_okay)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  // drive one packet on the next falling edge and queue the FSM outputs expected after it
  task automatic send(input logic [3:0] id, input int cnt, input logic rc = 1'b0);
    logic [7:0] e;
    int i, d;
    @(negedge clk_256M);
    packet_data    = {4'h0, id, 70'h0, 10'(cnt)};
    packet_valid   = 1'b1;
    reset_counters = rc;
    i = int'(id) - 13;
    if (rc) begin
      m_tot = 0;
      m_for = 0;
      for (int k = 0; k < N; k++) begin
        m_pk[k] = 0; m_mm[k] = 0; m_dr[k] = 0; m_sync[k] = 1'b0;
      end
    end else begin
      m_tot++;
      if (i >= 0 && i < N) begin
        m_pk[i]++;
        if (!m_sync[i]) m_sync[i] = 1'b1;
        else begin
          d = (cnt - int'(m_exp[i])) & 1023;
          if (d == 0) begin
            if (m_st[i] == 0) begin m_st[i] = 1; m_mc[i] = 1; end
            else if (m_st[i] == 1) begin
              if (m_mc[i] >= 16) m_st[i] = 2;
              else m_mc[i]++;
            end
          end else begin
            m_mm[i]++;
            if (d <= 8) m_dr[i] += d;
            m_st[i] = 0;
            m_mc[i] = 0;
          end
        end
        m_exp[i] = 10'(cnt + 1);
      end else m_for++;
    end
    for (int k = 0; k < N; k++) begin
      e[4+k] = m_st[k] == 2;
      e[k]   = m_st[k] != 0;
    end
    sb.push_back(e);
  endtask
  task automatic rd(input logic [3:0] sel);
    int unsigned ep, em, ed;
    @(negedge clk_256M);
    packet_valid   = 1'b0;
    reset_counters = 1'b0;
    stat_sel       = sel;
    ep = 0; em = 0; ed = 0;
    if (sel < N) begin
      ep = m_pk[sel[1:0]]; em = m_mm[sel[1:0]]; ed = m_dr[sel[1:0]];
    end
    @(negedge clk_256M);
    chk("total_packets", total_packets, m_tot);
    chk("foreign_packets", foreign_packets, m_for);
    chk("sel_packets", sel_packets, ep);
    chk("sel_mismatch", sel_mismatch, em);
    chk("sel_dropped", sel_dropped, ed);
  endtask
  always @(posedge clk_256M) begin
    if (reset_n && packet_valid) begin
      #1;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("led_link", {24'h0, okay_led, link_count_okay}, {24'h0, sb.pop_front()});
    end
  end
  initial begin
    int k;
    reset_n = 1'b0; packet_valid = 1'b0; reset_counters = 1'b0; packet_data = '0; stat_sel = '0;
    m_tot = 0; m_for = 0;
    for (int j = 0; j < N; j++) begin
      m_sync[j] = 1'b0; m_exp[j] = '0; m_pk[j] = 0; m_mm[j] = 0; m_dr[j] = 0; m_st[j] = 0; m_mc[j] = 0;
    end
    repeat (3) @(negedge clk_256M);
    chk("rst_total", total_packets, 0);
    chk("rst_foreign", foreign_packets, 0);
    chk("rst_sel", sel_packets | sel_mismatch | sel_dropped, 0);
    chk("rst_leds", {24'h0, okay_led, link_count_okay}, 0);
    reset_n = 1'b1;
    for (int c = 0; c < 100; c++) send(4'hD, c);
    rd(0);
    chk("d_pkts100", sel_packets, 100);
    chk("d_mism0", sel_mismatch, 0);
    chk("d_led_up", 32'(okay_led[0]), 1);
    rd(5);
    send(4'hE, 5); send(4'hE, 6); send(4'hE, 9);
    rd(1);
    chk("e_mism", sel_mismatch, 1);
    chk("e_drop", sel_dropped, 2);
    chk("e_link_down", 32'(link_count_okay[1]), 0);
    send(4'hD, 0, 1'b1);
    send(4'hD, 1022); send(4'hD, 1023); send(4'hD, 0); send(4'hD, 1);
    rd(0);
    chk("wrap_pkts", sel_packets, 4);
    chk("wrap_mism", sel_mismatch, 0);
    send(4'hF, 3); send(4'hF, 500);
    rd(2);
    chk("f_mism", sel_mismatch, 1);
    chk("f_drop", sel_dropped, 0);
    send(4'h2, 0, 1'b1);
    for (int c = 0; c < 5; c++) send(4'h2, c);
    rd(0);
    chk("foreign5", foreign_packets, 5);
    chk("total5", total_packets, 5);
    send(4'hD, 7, 1'b1);
    rd(0);
    chk("rc_total0", total_packets, 0);
    chk("rc_pkts0", sel_packets, 0);
    send(4'hD, 2); send(4'hD, 3);
    @(negedge clk_256M);
    packet_valid = 1'b0;
    repeat (TMO - 10) @(negedge clk_256M);
    chk("led_before_tmo", 32'(okay_led[0]), 1);
    k = 0;
    while (okay_led[0] && k < 40) begin
      @(negedge clk_256M);
      k++;
    end
    chk("led_after_tmo", 32'(okay_led[0]), 0);
    chk("link_after_tmo", 32'(link_count_okay[0]), 0);
`ifdef TELEMETRY_CHECK_SATURATE_EN
    @(negedge clk_256M);
    force dut.total_packets = 32'hFFFFFFFE;
    @(negedge clk_256M);
    release dut.total_packets;
    send(4'h2, 0); send(4'h2, 1); send(4'h2, 2);
    @(negedge clk_256M);
    packet_valid = 1'b0;
    @(negedge clk_256M);
    chk("sat_total", total_packets, 32'hFFFFFFFF);
`endif
    repeat (3) @(negedge clk_256M);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
